// File: rtl/popcount_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// popcount_scheduler : round-robin share of one external popcount datapath
// Revision 1.0
// ---------------------------------------------------------------------------
module popcount_scheduler #(
    parameter int WIDTH      = 32,
    parameter int NUM_REQ    = 4,
    parameter int PC_LATENCY = 3
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic                       en_i,
    input  logic [NUM_REQ-1:0]         req_val_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [WIDTH-1:0]           pc_data_o,
    output logic                       pc_data_val_o,
    input  logic [$clog2(WIDTH):0]     pc_data_i,
    input  logic                       pc_data_val_i,
    output logic [$clog2(WIDTH):0]     res_data_o,
    output logic [NUM_REQ-1:0]         res_val_o,
    output logic                       busy_o,
    output logic                       err_o
);
    localparam int                 c_CW   = $clog2(WIDTH) + 1;
    localparam int                 c_IDW  = $clog2(NUM_REQ);
    localparam logic [c_IDW:0]     c_NUM  = (c_IDW+1)'(NUM_REQ);
    localparam logic [c_IDW-1:0]   c_LAST = c_IDW'(NUM_REQ - 1);

    logic [c_IDW-1:0]      r_ptr;
    logic [WIDTH-1:0]      r_pc_data;
    logic                  r_pc_val;
    logic [c_IDW-1:0]      r_issue_id;
    logic [PC_LATENCY-1:0] r_tag_val;
    logic [c_IDW-1:0]      r_tag_id [PC_LATENCY];
    logic [c_CW-1:0]       r_res_data;
    logic [NUM_REQ-1:0]    r_res_val;
    logic                  r_err;

    logic [c_IDW:0]        w_idx;
    logic                  w_found;
    logic [c_IDW-1:0]      w_gnt_id;
    logic                  w_xfer;
    logic [WIDTH-1:0]      w_gnt_data;
    logic                  w_tail_val;
    logic [NUM_REQ-1:0]    w_tail_onehot;

    // First valid requester at or after r_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (c_IDW+1)'(k);
            if (w_idx >= c_NUM) begin
                w_idx = w_idx - c_NUM;
            end
            if (!w_found && req_val_i[w_idx[c_IDW-1:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx[c_IDW-1:0];
            end
        end
    end

    assign w_xfer        = en_i & w_found;
    assign req_ready_o   = w_xfer ? (NUM_REQ'(1) << w_gnt_id) : '0;
    assign w_gnt_data    = req_data_i[int'(w_gnt_id)*WIDTH +: WIDTH];
    assign w_tail_val    = r_tag_val[PC_LATENCY-1];
    assign w_tail_onehot = NUM_REQ'(1) << r_tag_id[PC_LATENCY-1];

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_ptr      <= '0;
            r_pc_data  <= '0;
            r_pc_val   <= 1'b0;
            r_issue_id <= '0;
            r_tag_val  <= '0;
            for (int s = 0; s < PC_LATENCY; s++) begin
                r_tag_id[s] <= '0;
            end
            r_res_data <= '0;
            r_res_val  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_pc_val <= w_xfer;
            if (w_xfer) begin
                r_pc_data  <= w_gnt_data;
                r_issue_id <= w_gnt_id;
                r_ptr      <= (w_gnt_id == c_LAST) ? '0 : w_gnt_id + 1'b1;
            end

            // Tag pipe shifts unconditionally; its tail lines up with pc_data_val_i.
            r_tag_val[0] <= r_pc_val;
            r_tag_id[0]  <= r_issue_id;
            for (int s = 1; s < PC_LATENCY; s++) begin
                r_tag_val[s] <= r_tag_val[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end

            r_res_val <= '0;
            if (pc_data_val_i && w_tail_val) begin
                r_res_data <= pc_data_i;
                r_res_val  <= w_tail_onehot;
            end
            if (pc_data_val_i != w_tail_val) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pc_data_o     = r_pc_data;
    assign pc_data_val_o = r_pc_val;
    assign res_data_o    = r_res_data;
    assign res_val_o     = r_res_val;
    assign err_o         = r_err;
    assign busy_o        = r_pc_val | (|r_tag_val) | (|r_res_val);

endmodule
`default_nettype wire

// File: tb/tb_popcount_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_popcount_scheduler : directed bench with a fixed-latency counter model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_popcount_scheduler;
    localparam int WIDTH      = 32;
    localparam int NUM_REQ    = 4;
    localparam int PC_LATENCY = 3;
    localparam int LAT        = PC_LATENCY + 2;
    localparam int LOGN       = 512;

    logic         clk     = 1'b0;
    logic         arst_n  = 1'b1;
    logic         en      = 1'b0;
    logic [3:0]   req_val = '0;
    logic [127:0] req_data = '0;
    logic         inject  = 1'b0;

    logic [3:0]   req_ready;
    logic [31:0]  pc_data;
    logic         pc_data_val;
    logic [5:0]   pc_cnt;
    logic         pc_cnt_val;
    logic [5:0]   res_data;
    logic [3:0]   res_val;
    logic         busy;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [3:0] log_ready [LOGN];
    logic [3:0] log_res   [LOGN];
    logic [5:0] log_data  [LOGN];
    logic       log_busy  [LOGN];
    logic       log_err   [LOGN];

    logic [PC_LATENCY-1:0] cm_val;
    logic [5:0]            cm_cnt [PC_LATENCY];

    popcount_scheduler #(
        .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .PC_LATENCY(PC_LATENCY)
    ) dut (
        .clk_i(clk),
        .arst_n_i(arst_n),
        .en_i(en),
        .req_val_i(req_val),
        .req_data_i(req_data),
        .req_ready_o(req_ready),
        .pc_data_o(pc_data),
        .pc_data_val_o(pc_data_val),
        .pc_data_i(pc_cnt),
        .pc_data_val_i(pc_cnt_val),
        .res_data_o(res_data),
        .res_val_o(res_val),
        .busy_o(busy),
        .err_o(err)
    );

    always #5 clk = ~clk;

    // External counter: fixed PC_LATENCY-cycle popcount.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cm_val <= '0;
            for (int s = 0; s < PC_LATENCY; s++) cm_cnt[s] <= '0;
        end else begin
            cm_val    <= {cm_val[PC_LATENCY-2:0], pc_data_val};
            cm_cnt[0] <= 6'($countones(pc_data));
            for (int s = 1; s < PC_LATENCY; s++) cm_cnt[s] <= cm_cnt[s-1];
        end
    end
    assign pc_cnt_val = cm_val[PC_LATENCY-1] | inject;
    assign pc_cnt     = cm_cnt[PC_LATENCY-1];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            log_ready[cyc] <= req_ready;
            log_res[cyc]   <= res_val;
            log_data[cyc]  <= res_data;
            log_busy[cyc]  <= busy;
            log_err[cyc]   <= err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_grant(input string t, input int c, input int id);
        check($sformatf("%s grant@%0d", t, c), 32'(log_ready[c]), 32'(1) << id);
    endtask

    task automatic exp_result(input string t, input int c, input int id, input int cnt);
        check($sformatf("%s res_val@%0d", t, c), 32'(log_res[c]), 32'(1) << id);
        check($sformatf("%s res_data@%0d", t, c), 32'(log_data[c]), 32'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int q;
        int nstb;
        int ids1 [4]  = '{1, 3, 1, 3};
        int cnt1 [4]  = '{1, 32, 1, 32};
        int cnts [4]  = '{1, 8, 16, 32};
        logic [127:0] data_a = {32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0000_00FF, 32'h0000_0001};

        // Asynchronous reset before any clock edge
        #2 arst_n = 1'b0;
        #1;
        check("rst pc_val",   32'(pc_data_val), 32'd0);
        check("rst pc_data",  pc_data,          32'd0);
        check("rst res_val",  32'(res_val),     32'd0);
        check("rst res_data", 32'(res_data),    32'd0);
        check("rst busy",     32'(busy),        32'd0);
        check("rst err",      32'(err),         32'd0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;

        // All four requesting for 8 cycles: RR 0,1,2,3,0,1,2,3
        tick();
        s = cyc;
        en = 1'b1;
        req_data = data_a;
        req_val = 4'b1111;
        repeat (8) tick();
        req_val = 4'b0000;
        repeat (LAT + 4) tick();
        for (int k = 0; k < 8; k++) begin
            exp_grant("rr4", s + k, k % 4);
            exp_result("rr4", s + k + LAT, k % 4, cnts[k % 4]);
        end
        for (int i = 0; i < 4; i++) begin
            nstb = 0;
            for (int c = s; c < s + 16; c++) nstb += int'(log_res[c][i]);
            check($sformatf("rr4 strobes req%0d", i), 32'(nstb), 32'd2);
        end

        // Requester 2 alone
        s = cyc;
        req_val = 4'b0100;
        repeat (4) tick();
        req_val = 4'b0000;
        repeat (LAT + 4) tick();
        for (int k = 0; k < 4; k++) begin
            exp_grant("solo2", s + k, 2);
            exp_result("solo2", s + k + LAT, 2, 16);
        end

        // Requesters 1 and 3; a lone grant to 1 first puts the pointer at 2
        req_data = {32'hFFFF_FFFF, 32'h0, 32'h0000_0001, 32'h0};
        s = cyc;
        req_val = 4'b0010;
        tick();
        req_val = 4'b1010;
        repeat (3) tick();
        req_val = 4'b0000;
        repeat (LAT + 4) tick();
        for (int k = 0; k < 4; k++) begin
            exp_grant("wrap", s + k, ids1[k]);
            exp_result("wrap", s + k + LAT, ids1[k], cnt1[k]);
        end

        // Enable dropped after three grants while requests remain
        req_data = data_a;
        s = cyc;
        req_val = 4'b1111;
        repeat (3) tick();
        en = 1'b0;
        repeat (3) tick();
        req_val = 4'b0000;
        repeat (6) tick();
        for (int k = 0; k < 3; k++) begin
            exp_grant("en", s + k, k);
            exp_result("en", s + k + LAT, k, cnts[k]);
            check($sformatf("en ready off@%0d", s + 3 + k), 32'(log_ready[s + 3 + k]), 32'd0);
        end
        check("en res after drain", 32'(log_res[s + 8]), 32'd0);
        check("en busy last res",   32'(log_busy[s + 7]), 32'd1);
        check("en busy drained",    32'(log_busy[s + 8]), 32'd0);
        check("en err",             32'(log_err[s + 8]), 32'd0);

        // Spurious counter valid with an empty tag pipe
        q = cyc;
        inject = 1'b1;
        tick();
        inject = 1'b0;
        repeat (6) tick();
        check("spur err before", 32'(log_err[q]),     32'd0);
        check("spur err set",    32'(log_err[q + 1]), 32'd1);
        check("spur no result",  32'(log_res[q + 1]), 32'd0);
        check("spur err sticky", 32'(log_err[q + 5]), 32'd1);

        // Reset with three tags in flight; pointer is 3 on entry
        en = 1'b1;
        s = cyc;
        req_val = 4'b1111;
        repeat (3) tick();
        req_val = 4'b0000;
        exp_grant("arst", s, 3);
        exp_grant("arst", s + 1, 0);
        exp_grant("arst", s + 2, 1);
        check("arst busy before", 32'(busy), 32'd1);
        #2 arst_n = 1'b0;
        #1;
        check("arst pc_val",   32'(pc_data_val), 32'd0);
        check("arst pc_data",  pc_data,          32'd0);
        check("arst res_val",  32'(res_val),     32'd0);
        check("arst res_data", 32'(res_data),    32'd0);
        check("arst busy",     32'(busy),        32'd0);
        check("arst err",      32'(err),         32'd0);
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (10) tick();
        nstb = 0;
        for (int c = s + 3; c < cyc; c++) nstb += int'(log_res[c] != 4'b0000);
        check("arst no results", 32'(nstb), 32'd0);
        check("arst err after", 32'(log_err[cyc - 1]), 32'd0);
        req_val = 4'b1111;
        #1;
        check("arst first grant", 32'(req_ready), 32'd1);
        tick();
        req_val = 4'b0000;
        repeat (LAT + 2) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/popcount_scheduler.md
Name: popcount_scheduler

Overview:
- Round-robin scheduler that shares one external population-counter datapath among NUM_REQ requesters.
- Accepts one request per cycle and tags it with its requester ID. The tag travels in a delay line matched to the counter latency, and the returned count is steered back to the originating requester.
- Sits between client blocks and the counter instance. It owns the counter's input valid and checks that every counter output lines up with an in-flight tag.

Parameters:
- WIDTH, 32, data word width fed to the counter.
- NUM_REQ, 4, number of requesters (2..16).
- PC_LATENCY, 3, cycles from pc_data_val_o high to the matching pc_data_val_i high (1..8).

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous active-low reset
- en_i  in  1  grant enable; when low no new requests are accepted, in-flight ones drain
- req_val_i  in  NUM_REQ  per-requester request valid
- req_data_i  in  NUM_REQ*WIDTH  per-requester data word, requester i at bits [WIDTH*(i+1)-1 : WIDTH*i]
- req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero)
- pc_data_o  out  WIDTH  word to counter
- pc_data_val_o  out  1  word valid to counter
- pc_data_i  in  $clog2(WIDTH)+1  count from counter
- pc_data_val_i  in  1  count valid from counter
- res_data_o  out  $clog2(WIDTH)+1  returned count (shared bus)
- res_val_o  out  NUM_REQ  one-hot result strobe to owning requester
- busy_o  out  1  any tag in flight or output register valid
- err_o  out  1  sticky tag/result misalignment flag

Behaviour:
- Reset (arst_n_i low, asynchronous):
  - pc_data_val_o, res_val_o, err_o and busy_o go to 0.
  - pc_data_o and res_data_o go to 0.
  - The whole tag pipe is invalid and the RR pointer is 0.
  - Deassertion is used synchronously; the first grant is possible on the first clock edge with arst_n_i high.
- Arbitration is combinational, one grant per cycle:
  - Search req_val_i starting at index ptr and wrapping modulo NUM_REQ. The first set bit wins.
  - req_ready_o = one-hot of the winner when en_i=1, else 0.
  - Transfer happens when req_val_i[i] & req_ready_o[i].
  - A requester must hold data and valid stable until ready; it may not drop valid before acceptance.
- Pointer update: on a transfer from index g, ptr <= (g+1) mod NUM_REQ. With no transfer, ptr holds.
- Issue register (1 cycle):
  - On transfer: pc_data_o <= winning data, pc_data_val_o <= 1.
  - Otherwise: pc_data_val_o <= 0 and pc_data_o holds.
- Tag pipe:
  - PC_LATENCY stages of {valid, id[$clog2(NUM_REQ)-1:0]}.
  - Stage 0 loads {pc_data_val_o, issued id}; it shifts every cycle with no stall.
  - The last stage aligns with pc_data_val_i.
- Return register (1 cycle):
  - When pc_data_val_i and the tail tag are both valid: res_data_o <= pc_data_i and res_val_o <= 1 << tail id.
  - Otherwise res_val_o <= 0 and res_data_o holds.
- End-to-end latency: requester accept edge to res_val_o high = PC_LATENCY+2 cycles.
- Throughput: 1 result per cycle sustained.
- Misalignment: pc_data_val_i != tail tag valid sets err_o <= 1 (sticky until reset). No result is delivered for that cycle.
- en_i low mid-stream: grants stop the same cycle, pipe drains, busy_o falls after the last result.
- busy_o = OR of pc_data_val_o, all tag valids and |res_val_o (registered signals only).
- Single requester active: it wins every cycle (pointer wraps back to it).
- Simultaneous grant and returning result are independent; no structural hazard.
- Reset mid-operation discards all in-flight tags; no result strobes appear after reset.

Test Plan:
- NUM_REQ=4, all req_val_i=4'b1111 held 8 cycles:
  - grants 0,1,2,3,0,1,2,3;
  - each requester gets exactly 2 res_val_o strobes;
  - each strobe arrives PC_LATENCY+2 cycles after its grant.
- Requester 2 only, data 32'hFFFF_0000, counter model returns 16:
  - req_ready_o=4'b0100 every cycle;
  - res_val_o=4'b0100 with res_data_o=16 at PC_LATENCY+2.
- Requesters 1 and 3 valid, ptr=2:
  - grant 3 first, then 1, then 3 (RR wrap);
  - results tagged to the matching indices with counts of 32'h1 -> 1 and 32'hFFFF_FFFF -> 32.
- en_i dropped after 3 grants with requesters still valid:
  - req_ready_o=0;
  - 3 results return;
  - busy_o low at grant3 + PC_LATENCY+3;
  - err_o stays 0.
- Counter model injects a spurious pc_data_val_i with the tail tag invalid:
  - err_o=1 next cycle and stays 1;
  - no res_val_o for that cycle.
- arst_n_i pulsed low with 3 tags in flight:
  - all outputs 0 immediately;
  - no res_val_o after release;
  - first grant after release goes to requester 0.
